// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch score RAM managers:
// default geometry, the writer state encoding and the cell address helper.
package nw_pkg;

    localparam int NW_N       = 8;
    localparam int NW_SCORE_W = 9;
    localparam int NW_GAP     = 2;
    localparam int NW_IDX_W   = $clog2(NW_N + 1);
    localparam int NW_ADDR_W  = $clog2((NW_N + 1) * (NW_N + 1));

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT_ROW = 3'd1,
        INIT_COL = 3'd2,
        FILL     = 3'd3,
        DONE     = 3'd4
    } nw_state_e;

    // Row-major address of cell (i,j) in an (n+1)x(n+1) matrix.
    function automatic logic [31:0] cell_addr(input logic [31:0] i,
                                              input logic [31:0] j,
                                              input logic [31:0] n);
        return i * (n + 32'd1) + j;
    endfunction

endpackage

// File: rtl/nw_idx_counter.sv
// Row-major (i,j) cell counter with load, increment, configurable wrap column
// and a column-only mode used for sweeping column 0.
module nw_idx_counter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             col_only,
    input  logic [IDX_W-1:0] load_i,
    input  logic [IDX_W-1:0] load_j,
    input  logic [IDX_W-1:0] col_start,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic             row_end,
    output logic             last
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N);

    logic [IDX_W-1:0] i_r;
    logic [IDX_W-1:0] j_r;

    // Index registers: load has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_r <= '0;
            j_r <= '0;
        end else if (load) begin
            i_r <= load_i;
            j_r <= load_j;
        end else if (inc) begin
            if (col_only) begin
                i_r <= i_r + IDX_W'(1);
            end else if (j_r == IDX_MAX) begin
                i_r <= i_r + IDX_W'(1);
                j_r <= col_start;
            end else begin
                j_r <= j_r + IDX_W'(1);
            end
        end
    end

    assign i       = i_r;
    assign j       = j_r;
    assign row_end = (j_r == IDX_MAX);
    assign last    = (i_r == IDX_MAX) && (col_only || (j_r == IDX_MAX));

endmodule

// File: rtl/score_ram_writer.sv
// Write-side manager of the NW score RAM: writes the gap-penalty border, then
// one handshaken score per cell row-major over (1,1)..(N,N).
module score_ram_writer
    import nw_pkg::*;
#(
    parameter int N       = NW_N,
    parameter int SCORE_W = NW_SCORE_W,
    parameter int GAP     = NW_GAP,
    parameter int IDX_W   = $clog2(N + 1),
    parameter int ADDR_W  = $clog2((N + 1) * (N + 1))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [SCORE_W-1:0] wdata,
    output logic [IDX_W-1:0]   i_idx,
    output logic [IDX_W-1:0]   j_idx,
    output logic               busy,
    output logic               done
);

    localparam int INIT_W = IDX_W + $clog2(GAP) + 1;

    nw_state_e state_r, state_s;

    logic               we_r, we_s;
    logic [ADDR_W-1:0]  waddr_r, waddr_s;
    logic [SCORE_W-1:0] wdata_r, wdata_s;
    logic               ready_r, ready_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               accept_s;

    logic               cnt_load_s, cnt_inc_s, cnt_col_only_s;
    logic [IDX_W-1:0]   cnt_load_i_s, cnt_load_j_s, cnt_col_start_s;
    logic [IDX_W-1:0]   cnt_i, cnt_j;
    logic               cnt_row_end, cnt_last;

    // Border value -(k*GAP), formed at INIT_W bits and sign-extended/truncated.
    function automatic logic [SCORE_W-1:0] init_score(input logic [IDX_W-1:0] k);
        logic signed [INIT_W-1:0] mag_v;
        logic signed [31:0]       ext_v;
        mag_v = signed'(INIT_W'(k) * INIT_W'(GAP));
        ext_v = 32'(-mag_v);
        return ext_v[SCORE_W-1:0];
    endfunction

    nw_idx_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load_s),
        .inc       (cnt_inc_s),
        .col_only  (cnt_col_only_s),
        .load_i    (cnt_load_i_s),
        .load_j    (cnt_load_j_s),
        .col_start (cnt_col_start_s),
        .i         (cnt_i),
        .j         (cnt_j),
        .row_end   (cnt_row_end),
        .last      (cnt_last)
    );

    assign accept_s = score_valid && ready_r;

    // Next-state, counter control and next output values.
    always_comb begin
        state_s         = state_r;
        we_s            = 1'b0;
        waddr_s         = waddr_r;
        wdata_s         = wdata_r;
        ready_s         = 1'b0;
        done_s          = 1'b0;
        cnt_load_s      = 1'b0;
        cnt_inc_s       = 1'b0;
        cnt_col_only_s  = 1'b0;
        cnt_load_i_s    = '0;
        cnt_load_j_s    = '0;
        cnt_col_start_s = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = INIT_ROW;
                    cnt_load_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            INIT_ROW: begin
                we_s    = 1'b1;
                waddr_s = ADDR_W'(cell_addr(32'(cnt_i), 32'(cnt_j), 32'(N)));
                wdata_s = init_score(cnt_j);
                if (cnt_row_end) begin
                    state_s      = INIT_COL;
                    cnt_load_s   = 1'b1;
                    cnt_load_i_s = IDX_W'(1);
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            INIT_COL: begin
                cnt_col_only_s = 1'b1;
                we_s           = 1'b1;
                waddr_s        = ADDR_W'(cell_addr(32'(cnt_i), 32'd0, 32'(N)));
                wdata_s        = init_score(cnt_i);
                if (cnt_last) begin
                    state_s      = FILL;
                    cnt_load_s   = 1'b1;
                    cnt_load_i_s = IDX_W'(1);
                    cnt_load_j_s = IDX_W'(1);
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            FILL: begin
                cnt_col_start_s = IDX_W'(1);
                // Ready stays low for the cycle after an accept so the compute
                // stage can fetch neighbours of the new cell.
                if (accept_s) begin
                    we_s    = 1'b1;
                    waddr_s = ADDR_W'(cell_addr(32'(cnt_i), 32'(cnt_j), 32'(N)));
                    wdata_s = score_in;
                    if (cnt_last) begin
                        state_s = DONE;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            DONE: begin
                done_s     = 1'b1;
                state_s    = IDLE;
                cnt_load_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            waddr_r <= '0;
            wdata_r <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            we_r    <= we_s;
            waddr_r <= waddr_s;
            wdata_r <= wdata_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign we          = we_r;
    assign waddr       = waddr_r;
    assign wdata       = wdata_r;
    assign score_ready = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign i_idx       = cnt_i;
    assign j_idx       = cnt_j;

endmodule

// File: tb/tb_score_ram_writer.sv
// Self-checking bench for score_ram_writer (N=4, GAP=2): reference write list
// built from the matrix rules, randomized handshakes, start/reset disturbances.
module tb_score_ram_writer;

    localparam int N   = 4;
    localparam int SW  = 9;
    localparam int GAP = 2;
    localparam int IW  = $clog2(N + 1);
    localparam int AW  = $clog2((N + 1) * (N + 1));
    localparam int NC  = N * N;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] score_in;
    logic          score_valid;
    logic          score_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [SW-1:0] wdata;
    logic [IW-1:0] i_idx;
    logic [IW-1:0] j_idx;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_mis = 0;

    score_ram_writer #(.N(N), .SCORE_W(SW), .GAP(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .score_in    (score_in),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .i_idx       (i_idx),
        .j_idx       (j_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int border(input int k);
        return ((1 << SW) - k * GAP) % (1 << SW);
    endfunction

    // mode 0: valid tied high, score = cell number; mode 1: random valid with
    // 3-cycle gaps after each accept; mode 2: valid high with 0x055 during init.
    task automatic run_matrix(input int mode, input bit disturb, input bit abort5,
                              input bit chain_next);
        int  exp_addr[$];
        int  exp_data[$];
        int  acc_cnt  = 0;
        int  wr_fill  = 0;
        int  gap      = 0;
        int  done_at  = -1;
        bit  pend     = 1'b0;
        bit  finished = 1'b0;
        bit  exp_we;
        int  ea, ed;
        for (int j = 0; j <= N; j++) begin
            exp_addr.push_back(j);
            exp_data.push_back(border(j));
        end
        for (int i = 1; i <= N; i++) begin
            exp_addr.push_back(i * (N + 1));
            exp_data.push_back(border(i));
        end
        start       = 1'b1;
        score_valid = (mode != 1);
        score_in    = (mode == 2) ? 9'h055 : 9'd1;
        for (int s = 1; s <= BUDGET && !finished; s++) begin
            @(posedge clk);
            #1;
            exp_we = (s >= 2 && s <= 2 * N + 2) || pend;
            chk("we", 32'(we), 32'(exp_we));
            if (we === 1'b1 && exp_we && exp_addr.size() > 0) begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                chk("waddr", 32'(waddr), 32'(ea));
                chk("wdata", 32'(wdata), 32'(ed));
                if (s > 2 * N + 2) wr_fill++;
            end
            if (s <= 2 * N + 2 || pend)
                chk("ready_low", 32'(score_ready), 32'd0);
            else if (mode == 0 && acc_cnt < NC)
                chk("ready_high", 32'(score_ready), 32'd1);
            if (s >= 2 * N + 2 && acc_cnt < NC) begin
                chk("i_idx", 32'(i_idx), 32'(acc_cnt / N + 1));
                chk("j_idx", 32'(j_idx), 32'(acc_cnt % N + 1));
            end
            if (done_at == s) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                finished = 1'b1;
            end else begin
                chk("done_low", 32'(done), 32'd0);
                chk("busy_high", 32'(busy), 32'd1);
            end
            if (pend && wr_fill == NC && done_at < 0) done_at = s + 1;
            pend = 1'b0;
            if (abort5 && wr_fill == 5) begin
                start       = 1'b0;
                score_valid = 1'b0;
                rst         = 1'b1;
                #1;
                chk("abort_we", 32'(we), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(score_ready), 32'd0);
                chk("abort_i", 32'(i_idx), 32'd0);
                chk("abort_j", 32'(j_idx), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (!finished) begin
                if (chain_next && done_at == s + 1) start = 1'b1;
                else start = disturb && (s == 6 || s == 13);
                case (mode)
                    1: begin
                        score_valid = (gap > 0) ? 1'b0 : 1'($urandom_range(0, 1));
                        if (gap > 0) gap--;
                        score_in = SW'($urandom);
                    end
                    2: begin
                        score_valid = 1'b1;
                        score_in    = (acc_cnt == 0) ? 9'h055 : SW'($urandom);
                    end
                    default: begin
                        score_valid = 1'b1;
                        score_in    = SW'(acc_cnt + 1);
                    end
                endcase
                if (score_valid && score_ready === 1'b1 && acc_cnt < NC) begin
                    pend = 1'b1;
                    exp_addr.push_back((acc_cnt / N + 1) * (N + 1) + acc_cnt % N + 1);
                    exp_data.push_back(int'(score_in));
                    acc_cnt++;
                    if (mode == 1) gap = 3;
                end
            end
        end
        chk("finished", 32'(finished), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        score_valid = 1'b0;
        score_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_ready", 32'(score_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_i", 32'(i_idx), 32'd0);
        chk("rst_j", 32'(j_idx), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_matrix(0, 1'b0, 1'b0, 1'b1);
        run_matrix(1, 1'b0, 1'b0, 1'b0);
        run_matrix(2, 1'b0, 1'b0, 1'b0);
        run_matrix(0, 1'b1, 1'b0, 1'b0);
        run_matrix(1, 1'b1, 1'b0, 1'b0);
        run_matrix(0, 1'b0, 1'b1, 1'b0);
        run_matrix(0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
